reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width in bits of each register.
REQ-002 SHALL have parameter ADDR_W, default 4: register address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads zero, ignores writes and is never busy.
REQ-004 SHALL have port clk  in  1: rising-edge clock, the only clock.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port clr  in  1: synchronous clear of all registers and busy bits.
REQ-007 SHALL have ports rd_addr_a, rd_addr_b  in  ADDR_W: read addresses.
REQ-008 SHALL have ports rd_data_a, rd_data_b  out  DATA_W: read data.
REQ-009 SHALL have ports wr_en (in, 1), wr_addr (in, ADDR_W) and wr_data (in, DATA_W): writeback port.
REQ-010 SHALL have ports iss_en (in, 1) and iss_addr (in, ADDR_W): issue request marking a destination register pending.
REQ-011 SHALL have ports busy_a, busy_b  out  1: the addressed source is pending and cannot be bypassed.
REQ-012 SHALL have port stall  out  1: issue not accepted this cycle.
REQ-013 SHALL have port num_busy  out  ADDR_W+1: count of pending registers.

Function
REQ-014 Reads SHALL be combinational, 0-cycle latency.
REQ-015 When wr_en=1 and wr_addr equals a read address, that read port SHALL return wr_data in the same cycle (write-through bypass).
REQ-016 With ZERO_REG=1, address 0 SHALL read 0, including under bypass.
REQ-017 With ZERO_REG=1, writes and issues to address 0 SHALL have no effect.
REQ-018 A write SHALL update register[wr_addr] at the rising edge of clk while wr_en=1.
REQ-019 Scoreboard: busy[iss_addr] SHALL be set at the edge on which iss_en=1 and stall=0.
REQ-020 Scoreboard: busy[wr_addr] SHALL be cleared at the edge on which wr_en=1.
REQ-021 If an accepted issue and a write target the same address in the same cycle, set SHALL win and the bit stays busy.
REQ-022 busy_x SHALL equal busy[rd_addr_x] AND NOT (wr_en AND wr_addr==rd_addr_x).
REQ-023 stall SHALL equal busy_a OR busy_b OR (iss_en AND busy[iss_addr] AND NOT (wr_en AND wr_addr==iss_addr)), the last term being a WAW hazard.
REQ-024 An issue presented while stall=1 SHALL be dropped; the requester holds iss_en until stall=0.
REQ-025 num_busy SHALL equal the popcount of busy bits, updated registered with them.
REQ-026 num_busy SHALL never exceed DEPTH-ZERO_REG.
REQ-027 clr=1 SHALL zero all registers and busy bits at the next edge.
REQ-028 clr SHALL take priority over a simultaneous write or issue.
REQ-029 While clr=1, read data and bypass SHALL behave normally until that edge.
REQ-030 All outputs SHALL be free of combinational loops from iss_en to stall other than through the iss_addr busy lookup.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, zero all registers and busy bits and set num_busy=0.
REQ-032 During reset, rd_data_a and rd_data_b SHALL be 0 except as bypass-driven by wr_en.
REQ-033 During reset, busy_a, busy_b and stall SHALL be 0.
REQ-034 Deassertion of rst_n mid-operation SHALL discard any in-flight issue or write of that cycle.
REQ-035 No initial-value preloading SHALL be used.

Structure
REQ-036 Package rf_pkg SHALL hold the DATA_W and ADDR_W defaults and the DEPTH derivation.
REQ-037 Scoreboard bits, set/clear priority and num_busy SHALL live in a sub-module reg_scoreboard.
REQ-038 The storage array and bypass mux SHALL stay in reg_file_sb.

Verification
REQ-039 Write 0x0005 to r3, then read a=r3 -> rd_data_a=0x0005 next cycle; a simultaneous write of 0x1234 to r3 with read a=r3 -> rd_data_a=0x1234 same cycle.
REQ-040 Write 0xFFFF to r0, then read a=r0 -> 0x0000; iss_addr=0 -> busy unchanged, num_busy=0.
REQ-041 Issue r5, then read b=r5 -> busy_b=1, stall=1; write r5=0x0042 -> busy_b=0, rd_data_b=0x0042 same cycle; num_busy 1->0.
REQ-042 With r7 busy, iss_en with iss_addr=7 -> stall=1, issue dropped; same cycle with wr_en and wr_addr=7 -> stall=0, r7 stays busy, num_busy=1.
REQ-043 Issue r1, r2 and r4, then clr=1 together with iss r6 -> all busy bits 0, num_busy=0, all reads 0.
REQ-044 Assert rst_n=0 between clock edges with r3=0x0005 and r3 busy -> rd_data of r3 reads 0x0000 and busy clears immediately.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults for the register file with scoreboard.
package rf_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // Number of architectural registers for a given address width.
  function automatic int rf_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

  localparam int DEPTH_DEF = rf_depth(ADDR_W_DEF);

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard: one busy bit per register, hazard
// detection for the issue port and a registered count of pending entries.
//
// Issue handshake: iss_en is the request (valid), ~stall is ready. An issue
// is accepted on a rising edge where iss_en=1 and stall=0. A request seen
// with stall=1 is dropped, and the requester keeps iss_en and iss_addr
// steady until stall drops.
module reg_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall,
  output logic [ADDR_W:0]   num_busy
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  num_busy_q, num_busy_d;
  logic             waw;
  logic             iss_ok;

  // Hazard lookup: a same-cycle writeback to the looked-up register
  // resolves the dependency, so it masks the busy bit.
  always_comb begin
    busy_a = busy_q[rd_addr_a] & ~(wr_en & (wr_addr == rd_addr_a));
    busy_b = busy_q[rd_addr_b] & ~(wr_en & (wr_addr == rd_addr_b));
    waw    = iss_en & busy_q[iss_addr] & ~(wr_en & (wr_addr == iss_addr));
    stall  = busy_a | busy_b | waw;
    iss_ok = iss_en & ~stall;
  end

  // Next busy vector: writeback clears, accepted issue sets (set wins),
  // register 0 is pinned idle when hardwired, and clr overrides everything.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (iss_ok) busy_d[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
    if (clr) busy_d = '0;
    num_busy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      num_busy_d = num_busy_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // Busy bits and their population count register together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      num_busy_q <= '0;
    end else begin
      busy_q     <= busy_d;
      num_busy_q <= num_busy_d;
    end
  end

  assign num_busy = num_busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with write-through bypass and an
// attached scoreboard tracking registers with an outstanding producer.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall,
  output logic [ADDR_W:0]   num_busy
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr_live;

  // Writes to a hardwired zero register are discarded.
  assign wr_live = wr_en & ~((ZERO_REG != 0) && (wr_addr == '0));

  // Next storage contents: clr beats the writeback.
  always_comb begin
    regs_d = regs_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
    end else if (wr_live) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Storage array, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational reads with write-through bypass; register 0 forced to 0.
  always_comb begin
    rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : regs_q[rd_addr_a];
    rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : regs_q[rd_addr_b];
    if ((ZERO_REG != 0) && (rd_addr_a == '0)) rd_data_a = '0;
    if ((ZERO_REG != 0) && (rd_addr_b == '0)) rd_data_b = '0;
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .stall     (stall),
    .num_busy  (num_busy)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with default parameters (16-bit, 16 regs,
// register 0 hardwired). Inputs change 1 ns after a rising edge; outputs are
// sampled 1 ns after that, well away from the next edge.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        iss_en;
  logic [3:0]  iss_addr;
  logic        busy_a, busy_b, stall;
  logic [4:0]  num_busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_v;

  reg_file_sb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .stall     (stall),
    .num_busy  (num_busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic drive_iss(input logic [3:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    #1;
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL reset_rd_a: got %h expected %h", rd_data_a, 16'h0); end
    checks++; if (num_busy !== 5'd0) begin errors++; $display("FAIL reset_num_busy: got %0d expected 0", num_busy); end
    checks++; if ({busy_a, busy_b, stall} !== 3'b000) begin errors++; $display("FAIL reset_busy_stall: got %b expected 000", {busy_a, busy_b, stall}); end
    drive_wr(4'd3, 16'hABCD); rd_addr_a = 4'd3;
    #1;
    checks++; if (rd_data_a !== 16'hABCD) begin errors++; $display("FAIL reset_bypass: got %h expected %h", rd_data_a, 16'hABCD); end
    tick();
    idle(); rd_addr_a = 4'd3;
    #1;
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL reset_no_write: got %h expected %h", rd_data_a, 16'h0); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    idle(); drive_wr(4'd3, 16'h0005);
    tick();
    idle(); rd_addr_a = 4'd3;
    #1;
    checks++; if (rd_data_a !== 16'h0005) begin errors++; $display("FAIL wr_rd_r3: got %h expected %h", rd_data_a, 16'h0005); end
    drive_wr(4'd3, 16'h1234);
    #1;
    checks++; if (rd_data_a !== 16'h1234) begin errors++; $display("FAIL bypass_r3: got %h expected %h", rd_data_a, 16'h1234); end
    tick();
    idle(); rd_addr_b = 4'd3;
    #1;
    checks++; if (rd_data_b !== 16'h1234) begin errors++; $display("FAIL stored_r3_b: got %h expected %h", rd_data_b, 16'h1234); end
  endtask

  task automatic test_zero_reg();
    idle(); drive_wr(4'd0, 16'hFFFF); rd_addr_a = 4'd0;
    #1;
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL r0_bypass: got %h expected %h", rd_data_a, 16'h0); end
    tick();
    idle(); drive_iss(4'd0);
    #1;
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL r0_read: got %h expected %h", rd_data_a, 16'h0); end
    tick();
    idle();
    #1;
    checks++; if (num_busy !== 5'd0) begin errors++; $display("FAIL r0_issue_count: got %0d expected 0", num_busy); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL r0_busy: got %b expected 0", busy_a); end
  endtask

  task automatic test_issue_bypass();
    idle(); drive_iss(4'd5);
    tick();
    idle(); rd_addr_b = 4'd5;
    #1;
    checks++; if (num_busy !== 5'd1) begin errors++; $display("FAIL iss5_count: got %0d expected 1", num_busy); end
    checks++; if ({busy_b, stall} !== 2'b11) begin errors++; $display("FAIL iss5_busy_stall: got %b expected 11", {busy_b, stall}); end
    drive_wr(4'd5, 16'h0042);
    #1;
    checks++; if ({busy_b, stall} !== 2'b00) begin errors++; $display("FAIL wb5_busy_stall: got %b expected 00", {busy_b, stall}); end
    checks++; if (rd_data_b !== 16'h0042) begin errors++; $display("FAIL wb5_bypass: got %h expected %h", rd_data_b, 16'h0042); end
    tick();
    idle(); rd_addr_b = 4'd5;
    #1;
    checks++; if (num_busy !== 5'd0) begin errors++; $display("FAIL wb5_count: got %0d expected 0", num_busy); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL wb5_busy_after: got %b expected 0", busy_b); end
  endtask

  task automatic test_waw();
    idle(); drive_iss(4'd7);
    tick();
    idle(); drive_iss(4'd7);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b expected 1", stall); end
    tick();
    // Source hazard on port a drops an issue to an idle register.
    idle(); rd_addr_a = 4'd7; drive_iss(4'd2);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b expected 1", stall); end
    tick();
    idle(); rd_addr_a = 4'd2;
    #1;
    checks++; if (num_busy !== 5'd1) begin errors++; $display("FAIL dropped_count: got %0d expected 1", num_busy); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL dropped_r2: got %b expected 0", busy_a); end
    idle(); drive_iss(4'd7); drive_wr(4'd7, 16'h0077);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_resolved: got %b expected 0", stall); end
    tick();
    idle(); rd_addr_a = 4'd7;
    #1;
    checks++; if (num_busy !== 5'd1) begin errors++; $display("FAIL set_wins_count: got %0d expected 1", num_busy); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL set_wins_busy: got %b expected 1", busy_a); end
    checks++; if (rd_data_a !== 16'h0077) begin errors++; $display("FAIL set_wins_data: got %h expected %h", rd_data_a, 16'h0077); end
    idle(); drive_wr(4'd7, 16'h0070);
    tick();
    idle();
  endtask

  task automatic test_clear();
    idle(); drive_wr(4'd1, 16'h0011);
    tick();
    idle(); drive_wr(4'd4, 16'h0044);
    tick();
    idle(); drive_iss(4'd1); tick();
    idle(); drive_iss(4'd2); tick();
    idle(); drive_iss(4'd4); tick();
    idle();
    #1;
    checks++; if (num_busy !== 5'd3) begin errors++; $display("FAIL pre_clr_count: got %0d expected 3", num_busy); end
    clr = 1'b1; drive_iss(4'd6); drive_wr(4'd2, 16'h0022); rd_addr_a = 4'd2; rd_addr_b = 4'd9;
    #1;
    checks++; if (rd_data_a !== 16'h0022) begin errors++; $display("FAIL clr_bypass: got %h expected %h", rd_data_a, 16'h0022); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL clr_stall: got %b expected 0", stall); end
    rd_addr_b = 4'd1;
    #1;
    checks++; if (rd_data_b !== 16'h0011) begin errors++; $display("FAIL clr_read_r1: got %h expected %h", rd_data_b, 16'h0011); end
    rd_addr_b = 4'd9;
    tick();
    idle(); rd_addr_a = 4'd1; rd_addr_b = 4'd4;
    #1;
    checks++; if (num_busy !== 5'd0) begin errors++; $display("FAIL post_clr_count: got %0d expected 0", num_busy); end
    checks++; if ({rd_data_a, rd_data_b} !== 32'h0) begin errors++; $display("FAIL post_clr_data: got %h expected 0", {rd_data_a, rd_data_b}); end
    checks++; if ({busy_a, busy_b} !== 2'b00) begin errors++; $display("FAIL post_clr_busy14: got %b expected 00", {busy_a, busy_b}); end
    rd_addr_a = 4'd2; rd_addr_b = 4'd6;
    #1;
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL post_clr_r2: got %h expected 0", rd_data_a); end
    checks++; if ({busy_a, busy_b} !== 2'b00) begin errors++; $display("FAIL post_clr_busy26: got %b expected 00", {busy_a, busy_b}); end
  endtask

  task automatic test_async_reset();
    idle(); drive_wr(4'd3, 16'h0005); tick();
    idle(); drive_iss(4'd3); tick();
    idle(); rd_addr_a = 4'd3;
    #1;
    checks++; if ({rd_data_a, busy_a} !== {16'h0005, 1'b1}) begin errors++; $display("FAIL pre_rst_r3: got %h/%b expected 0005/1", rd_data_a, busy_a); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL async_rst_data: got %h expected 0", rd_data_a); end
    checks++; if ({busy_a, stall} !== 2'b00) begin errors++; $display("FAIL async_rst_busy: got %b expected 00", {busy_a, stall}); end
    checks++; if (num_busy !== 5'd0) begin errors++; $display("FAIL async_rst_count: got %0d expected 0", num_busy); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      idle(); drive_wr(4'(8 + i), 16'hA000 + 16'(i * 16'h0111));
      exp_q.push_back(16'hA000 + 16'(i * 16'h0111));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      idle(); rd_addr_a = 4'(8 + i);
      #1;
      exp_v = exp_q.pop_front();
      checks++; if (rd_data_a !== exp_v) begin errors++; $display("FAIL b2b_read r%0d: got %h expected %h", 8 + i, rd_data_a, exp_v); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      idle(); drive_iss(4'(8 + i)); tick();
      checks++; if (num_busy !== 5'(i + 1)) begin errors++; $display("FAIL b2b_iss_count: got %0d expected %0d", num_busy, i + 1); end
    end
    for (int i = 0; i < 4; i++) begin
      idle(); drive_wr(4'(8 + i), 16'h5A00 + 16'(i)); rd_addr_a = 4'(8 + i);
      #1;
      checks++; if ({rd_data_a, busy_a} !== {16'h5A00 + 16'(i), 1'b0}) begin errors++; $display("FAIL b2b_wb_bypass: got %h/%b expected %h/0", rd_data_a, busy_a, 16'h5A00 + 16'(i)); end
      tick();
      checks++; if (num_busy !== 5'(3 - i)) begin errors++; $display("FAIL b2b_wb_count: got %0d expected %0d", num_busy, 3 - i); end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      idle(); drive_iss(4'(i)); tick();
    end
    idle();
    #1;
    checks++; if (num_busy !== 5'd15) begin errors++; $display("FAIL fill_count: got %0d expected 15", num_busy); end
    clr = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (num_busy !== 5'd0) begin errors++; $display("FAIL fill_clr_count: got %0d expected 0", num_busy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_issue_bypass();
    test_waw();
    test_clear();
    test_async_reset();
    test_back_to_back();
    test_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
